// File: rtl/accum_cpu_pkg.sv
// Shared opcode values, FSM state encoding and opcode decode helpers for accum_cpu.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package accum_cpu_pkg;

  localparam int OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP     = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDA_IMM = 4'h1;
  localparam logic [OPC_W-1:0] OP_LDA_MEM = 4'h2;
  localparam logic [OPC_W-1:0] OP_STA_MEM = 4'h3;
  localparam logic [OPC_W-1:0] OP_ADD_IMM = 4'h4;
  localparam logic [OPC_W-1:0] OP_ADD_MEM = 4'h5;
  localparam logic [OPC_W-1:0] OP_SUB_IMM = 4'h6;
  localparam logic [OPC_W-1:0] OP_SUB_MEM = 4'h7;
  localparam logic [OPC_W-1:0] OP_JMP     = 4'h8;
  localparam logic [OPC_W-1:0] OP_JZ      = 4'h9;
  localparam logic [OPC_W-1:0] OP_JC      = 4'hA;
  localparam logic [OPC_W-1:0] OP_IN      = 4'hB;
  localparam logic [OPC_W-1:0] OP_OUT     = 4'hC;
  localparam logic [OPC_W-1:0] OP_HLT     = 4'hF;

  typedef enum logic [2:0] {
    ST_HALT,
    ST_FETCH,
    ST_OPND,
    ST_MEM,
    ST_EXEC
  } state_t;

  // Single-word instructions: NOP, HLT and the two illegal codes D/E.
  function automatic logic has_opnd(input logic [OPC_W-1:0] op);
    return !(op == OP_NOP || op == OP_HLT || op == 4'hD || op == 4'hE);
  endfunction

  // Instructions that need a data read from mem[operand] before EXEC.
  function automatic logic is_mem_rd(input logic [OPC_W-1:0] op);
    return (op == OP_LDA_MEM || op == OP_ADD_MEM || op == OP_SUB_MEM);
  endfunction

endpackage

// File: rtl/accum_cpu_ram.sv
// Unified program/data memory, 2**ADDR_W x DATA_W, not cleared by reset.
// Latency: combinational read, write commits on the rising clock edge.
// Backpressure: none; a write is accepted every cycle we is high.
module accum_cpu_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/accum_cpu.sv
// Multi-cycle accumulator CPU with carry/zero flags, multi-port IN/OUT and a halted program-load port.
// Latency: 2 cycles NOP/HLT/illegal, 3 cycles imm/jump/IN/OUT/STA, 4 cycles LDA/ADD/SUB from memory.
// Backpressure: none; io ports are sampled/strobed without handshake, prog port only honoured while halted.
module accum_cpu
  import accum_cpu_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int ADDR_W       = 8,
  parameter int NUM_IO       = 2,
  parameter bit START_HALTED = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     run,
  input  logic                     prog_we,
  input  logic [ADDR_W-1:0]        prog_addr,
  input  logic [DATA_W-1:0]        prog_data,
  input  logic [NUM_IO*DATA_W-1:0] io_in,
  output logic [NUM_IO*DATA_W-1:0] io_out,
  output logic [NUM_IO-1:0]        io_out_valid,
  output logic                     halted,
  output logic [ADDR_W-1:0]        pc_dbg
);

  localparam state_t RST_STATE = START_HALTED ? ST_HALT : ST_FETCH;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] opnd;
  logic [DATA_W-1:0] mdat;
  logic [OPC_W-1:0]  ir;
  logic              z;
  logic              c;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic [DATA_W-1:0] ram_rdata;

  logic [ADDR_W-1:0] opnd_addr;
  logic [DATA_W-1:0] b_val;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   dif;
  logic              in_ok;
  logic [DATA_W-1:0] in_val;

  assign opnd_addr = opnd[ADDR_W-1:0];
  assign halted    = (state == ST_HALT);
  assign pc_dbg    = pc;

  // Memory port muxing: the program port owns the write side while halted,
  // STA owns it in EXEC; the read side follows pc except during the MEM step.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = prog_addr;
    ram_wdata = prog_data;
    if (state == ST_HALT && prog_we) begin
      ram_we = 1'b1;
    end else if (state == ST_EXEC && ir == OP_STA_MEM) begin
      ram_we    = 1'b1;
      ram_waddr = opnd_addr;
      ram_wdata = acc;
    end
    ram_raddr = (state == ST_MEM) ? opnd_addr : pc;
  end

  accum_cpu_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // ALU operands and results; borrow is the top bit of the widened difference.
  always_comb begin
    b_val  = is_mem_rd(ir) ? mdat : opnd;
    sum    = {1'b0, acc} + {1'b0, b_val};
    dif    = {1'b0, acc} - {1'b0, b_val};
    in_ok  = 1'b0;
    in_val = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      if (opnd == DATA_W'(k)) begin
        in_ok  = 1'b1;
        in_val = io_in[k*DATA_W +: DATA_W];
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RST_STATE;
    else        state <= state_nxt;
  end

  // Next-state decode: operand fetch only for two-word opcodes, MEM step only for memory reads.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HALT:  if (run) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = has_opnd(ram_rdata[OPC_W-1:0]) ? ST_OPND : ST_EXEC;
      ST_OPND:  state_nxt = is_mem_rd(ir) ? ST_MEM : ST_EXEC;
      ST_MEM:   state_nxt = ST_EXEC;
      ST_EXEC:  state_nxt = (ir == OP_HLT) ? ST_HALT : ST_FETCH;
      default:  state_nxt = RST_STATE;
    endcase
  end

  // Datapath: instruction/operand latching, then result commit in EXEC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc           <= '0;
      acc          <= '0;
      opnd         <= '0;
      mdat         <= '0;
      ir           <= '0;
      z            <= 1'b0;
      c            <= 1'b0;
      io_out       <= '0;
      io_out_valid <= '0;
    end else begin
      io_out_valid <= '0;
      case (state)
        ST_FETCH: begin
          ir <= ram_rdata[OPC_W-1:0];
          pc <= pc + ADDR_W'(1);
        end
        ST_OPND: begin
          opnd <= ram_rdata;
          pc   <= pc + ADDR_W'(1);
        end
        ST_MEM: mdat <= ram_rdata;
        ST_EXEC: begin
          case (ir)
            OP_LDA_IMM, OP_LDA_MEM: begin
              acc <= b_val;
              z   <= (b_val == '0);
              c   <= 1'b0;
            end
            OP_ADD_IMM, OP_ADD_MEM: begin
              acc <= sum[DATA_W-1:0];
              z   <= (sum[DATA_W-1:0] == '0);
              c   <= sum[DATA_W];
            end
            OP_SUB_IMM, OP_SUB_MEM: begin
              acc <= dif[DATA_W-1:0];
              z   <= (dif[DATA_W-1:0] == '0);
              c   <= dif[DATA_W];
            end
            OP_JMP: pc <= opnd_addr;
            OP_JZ:  if (z) pc <= opnd_addr;
            OP_JC:  if (c) pc <= opnd_addr;
            OP_IN: begin
              if (in_ok) begin
                acc <= in_val;
                z   <= (in_val == '0);
                c   <= 1'b0;
              end
            end
            OP_OUT: begin
              for (int k = 0; k < NUM_IO; k++) begin
                if (opnd == DATA_W'(k)) begin
                  io_out[k*DATA_W +: DATA_W] <= acc;
                  io_out_valid[k]            <= 1'b1;
                end
              end
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_cpu.sv
// Directed bench for accum_cpu: small programs loaded through the prog port, run, and checked.
// Latency: checks exact cycle counts from run to halt and strobe timing.
// Backpressure: not applicable.
module tb_accum_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        prog_we = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic [7:0]  prog_data = '0;
  logic [15:0] io_in = {8'd42, 8'h99};
  logic [15:0] io_out;
  logic [1:0]  io_out_valid;
  logic        halted;
  logic [7:0]  pc_dbg;

  int total = 0;
  int bad   = 0;

  int          cyc;
  int          vcnt0;
  int          vcnt1;
  int          vcyc0;
  logic [7:0]  vval0;
  logic [7:0]  pc_c1;

  accum_cpu #(
    .DATA_W       (8),
    .ADDR_W       (8),
    .NUM_IO       (2),
    .START_HALTED (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .run          (run),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .io_in        (io_in),
    .io_out       (io_out),
    .io_out_valid (io_out_valid),
    .halted       (halted),
    .pc_dbg       (pc_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we = 1'b0;
  endtask

  // Pulse run (optionally with a same-cycle program write), then count cycles until halted.
  task automatic go(input logic we_en, input logic [7:0] wa, input logic [7:0] wd);
    run       = 1'b1;
    prog_we   = we_en;
    prog_addr = wa;
    prog_data = wd;
    tick();
    run     = 1'b0;
    prog_we = 1'b0;
    check("left_halt", halted, 1'b0);
    cyc   = 0;
    vcnt0 = 0;
    vcnt1 = 0;
    vcyc0 = 0;
    vval0 = '0;
    pc_c1 = '0;
    while (!halted && cyc < 300) begin
      tick();
      cyc++;
      if (cyc == 1) pc_c1 = pc_dbg;
      if (io_out_valid[0]) begin
        vcnt0++;
        vcyc0 = cyc;
        vval0 = io_out[7:0];
      end
      if (io_out_valid[1]) vcnt1++;
    end
    check("halt_reached", halted, 1'b1);
  endtask

  initial begin
    // Test 1: reset state with START_HALTED=1
    do_reset();
    check("rst_halted", halted, 1'b1);
    check("rst_pc", pc_dbg, 8'h00);
    check("rst_io_out", io_out, 16'h0000);
    check("rst_valid", io_out_valid, 2'b00);

    // Test 2: LDA 10; ADD 5; STA 0x20; OUT 0; HLT (HLT byte written with the run pulse)
    load(8'h00, 8'h01); load(8'h01, 8'h0A);
    load(8'h02, 8'h04); load(8'h03, 8'h05);
    load(8'h04, 8'h03); load(8'h05, 8'h20);
    load(8'h06, 8'h0C); load(8'h07, 8'h00);
    check("still_halted", halted, 1'b1);
    run       = 1'b1;
    prog_we   = 1'b1;
    prog_addr = 8'h08;
    prog_data = 8'h0F;
    tick();
    run     = 1'b0;
    prog_we = 1'b0;
    check("t1_fetch_next", halted, 1'b0);
    check("t1_pc_before_fetch", pc_dbg, 8'h00);
    cyc   = 0;
    vcnt0 = 0;
    vcnt1 = 0;
    vcyc0 = 0;
    vval0 = '0;
    while (!halted && cyc < 300) begin
      tick();
      cyc++;
      if (io_out_valid[0]) begin
        vcnt0++;
        vcyc0 = cyc;
        vval0 = io_out[7:0];
      end
      if (io_out_valid[1]) vcnt1++;
    end
    check("t2_cycles", cyc, 14);
    check("t2_valid0_cnt", vcnt0, 1);
    check("t2_valid0_cyc", vcyc0, 12);
    check("t2_out0_at_valid", vval0, 8'd15);
    check("t2_valid1_cnt", vcnt1, 0);
    check("t2_out0_hold", io_out[7:0], 8'd15);
    check("t2_ram20", dut.u_ram.mem[8'h20], 8'd15);
    check("t2_pc_after_hlt", pc_dbg, 8'h09);

    // Test 3: carry/zero flags observed through taken/not-taken jumps
    do_reset();
    load(8'h00, 8'h01); load(8'h01, 8'hF0);
    load(8'h02, 8'h04); load(8'h03, 8'h20);
    load(8'h04, 8'h0A); load(8'h05, 8'h08);
    load(8'h06, 8'h0F);
    load(8'h08, 8'h0C); load(8'h09, 8'h00);
    load(8'h0A, 8'h06); load(8'h0B, 8'h10);
    load(8'h0C, 8'h09); load(8'h0D, 8'h10);
    load(8'h0E, 8'h0F);
    load(8'h10, 8'h0A); load(8'h11, 8'h1A);
    load(8'h12, 8'h01); load(8'h13, 8'h77);
    load(8'h14, 8'h0C); load(8'h15, 8'h01);
    load(8'h16, 8'h0F);
    load(8'h1A, 8'h0F);
    go(1'b0, 8'h00, 8'h00);
    check("t3_cycles", cyc, 29);
    check("t3_out0_add_carry", io_out[7:0], 8'h10);
    check("t3_out1", io_out[15:8], 8'h77);
    check("t3_pc_end", pc_dbg, 8'h17);

    // Test 4: IN from port 1, out-of-range IN/OUT index has no effect
    do_reset();
    load(8'h00, 8'h01); load(8'h01, 8'h07);
    load(8'h02, 8'h0B); load(8'h03, 8'h05);
    load(8'h04, 8'h0C); load(8'h05, 8'h01);
    load(8'h06, 8'h0B); load(8'h07, 8'h01);
    load(8'h08, 8'h0C); load(8'h09, 8'h00);
    load(8'h0A, 8'h09); load(8'h0B, 8'h30);
    load(8'h0C, 8'h0C); load(8'h0D, 8'h05);
    load(8'h0E, 8'h0F);
    load(8'h30, 8'h0F);
    go(1'b0, 8'h00, 8'h00);
    check("t4_cycles", cyc, 23);
    check("t4_out0_in1", io_out[7:0], 8'd42);
    check("t4_out1_in5_noeffect", io_out[15:8], 8'd7);
    check("t4_valid0_cnt", vcnt0, 1);
    check("t4_valid1_cnt", vcnt1, 1);
    check("t4_pc_end_jz_not_taken", pc_dbg, 8'h0F);

    // Test 5: pc wrap at 0xFF and SUB_MEM borrow
    do_reset();
    load(8'h00, 8'h08); load(8'h01, 8'hFE);
    load(8'hFE, 8'h0F);
    go(1'b0, 8'h00, 8'h00);
    check("t5_jmp_cycles", cyc, 5);
    check("t5_pc_ff", pc_dbg, 8'hFF);
    load(8'hFF, 8'h00);
    load(8'h00, 8'h01); load(8'h01, 8'h05);
    load(8'h02, 8'h07); load(8'h03, 8'h40);
    load(8'h04, 8'h0C); load(8'h05, 8'h00);
    load(8'h06, 8'h0A); load(8'h07, 8'h0A);
    load(8'h08, 8'h0F);
    load(8'h0A, 8'h0F);
    load(8'h40, 8'h06);
    go(1'b0, 8'h00, 8'h00);
    check("t5_pc_wrap", pc_c1, 8'h00);
    check("t5_cycles", cyc, 17);
    check("t5_sub_mem", io_out[7:0], 8'hFF);
    check("t5_pc_end_jc_taken", pc_dbg, 8'h0B);

    // Test 6: reset mid ADD_MEM, prog_we while running ignored
    load(8'h50, 8'h11);
    load(8'h0B, 8'h05); load(8'h0C, 8'h40);
    load(8'h0D, 8'h0F);
    run = 1'b1;
    tick();
    run       = 1'b0;
    prog_we   = 1'b1;
    prog_addr = 8'h50;
    prog_data = 8'h55;
    check("t6_running", halted, 1'b0);
    tick();
    tick();
    prog_we = 1'b0;
    check("t6_pc_mid", pc_dbg, 8'h0D);
    check("t6_out_before_rst", io_out[7:0], 8'hFF);
    reset = 1'b0;
    #1;
    check("t6_rst_halted", halted, 1'b1);
    check("t6_rst_pc", pc_dbg, 8'h00);
    check("t6_rst_io_out", io_out, 16'h0000);
    check("t6_rst_valid", io_out_valid, 2'b00);
    tick();
    reset = 1'b1;
    tick();
    check("t6_post_rst_halted", halted, 1'b1);
    check("t6_prog_we_ignored", dut.u_ram.mem[8'h50], 8'h11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
